// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Pure declarations, no timing.
// No flow control here; used by the stage and its load aligner.
package mem_stage_pkg;

    // Memory operation carried down the pipe from decode.
    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_t;

    // Access size as driven on dreq_size.
    localparam logic [1:0] MSIZE_1 = 2'd0;
    localparam logic [1:0] MSIZE_2 = 2'd1;
    localparam logic [1:0] MSIZE_4 = 2'd2;

    // Stage controller: either free, or holding one outstanding access.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [1:0] op_size(input mem_op_t op);
        case (op)
            LB, LBU, SB: return MSIZE_1;
            LH, LHU, SH: return MSIZE_2;
            default:     return MSIZE_4;
        endcase
    endfunction

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == MSIZE_2) && addr_lo[0]) ||
               ((size == MSIZE_4) && (addr_lo != 2'b00));
    endfunction

    // Byte lanes touched by a store; loads never assert strobes.
    function automatic logic [3:0] store_strobe(input mem_op_t op, input logic [1:0] addr_lo);
        case (op)
            SB:      return 4'b0001 << addr_lo;
            SH:      return 4'b0011 << addr_lo;
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate narrow store data across the word so any strobed lane sees it.
    function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] src);
        case (op)
            SB:      return {4{src[7:0]}};
            SH:      return {2{src[15:0]}};
            default: return src;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the M-stage input, data-bus request/response and writeback triple.
// Wires only, no timing.
// m_ready and dresp_data_ok carry the flow control; see mem_stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    // Upstream (execute/memory pipeline register)
    logic        m_valid;
    mem_op_t     m_op;
    logic [31:0] m_val;
    logic [31:0] m_store;
    logic [4:0]  m_dst;
    logic [3:0]  m_write_enable;
    logic        m_ready;
    logic        m_misalign;

    // Data bus
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    // Writeback triple
    logic [31:0] W_val3;
    logic [4:0]  W_dst;
    logic [3:0]  W_write_enable;

    // The stage itself.
    modport master (
        input  m_valid, m_op, m_val, m_store, m_dst, m_write_enable,
        output m_ready, m_misalign,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_data_ok, dresp_data,
        output W_val3, W_dst, W_write_enable
    );

    // Surroundings: upstream register, data memory, writeback register.
    modport slave (
        output m_valid, m_op, m_val, m_store, m_dst, m_write_enable,
        input  m_ready, m_misalign,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_data_ok, dresp_data,
        input  W_val3, W_dst, W_write_enable
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of the raw read word and sign/zero-extends it.
// Combinational, zero latency.
// No flow control; result is only meaningful when the load completes.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] val
);

    logic [31:0] lane;

    // Shift the addressed byte down to bit 0, then extend by op
    always_comb begin
        lane = raw >> {addr_lo, 3'b000};
        case (op)
            LB:      val = {{24{lane[7]}}, lane[7:0]};
            LBU:     val = {24'd0, lane[7:0]};
            LH:      val = {{16{lane[15]}}, lane[15:0]};
            LHU:     val = {16'd0, lane[15:0]};
            default: val = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores, aligns load data, drives the writeback triple.
// Same-cycle completion on zero-wait responses, otherwise completes in the data_ok cycle.
// Holds upstream with m_ready=0 while an access is outstanding; one request at a time.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.master  bus
);

    mem_state_t  state;
    mem_state_t  state_nxt;

    // Request captured at issue so WAIT never looks at the live inputs.
    mem_op_t     lat_op;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic [3:0]  lat_strobe;
    logic [31:0] lat_data;
    logic [4:0]  lat_dst;
    logic [3:0]  lat_write_enable;

    // Request as decoded from the live inputs.
    logic        live_mem;
    logic [1:0]  live_size;
    logic        live_misalign;
    logic [3:0]  live_strobe;
    logic [31:0] live_data;
    logic        issue;

    // Request currently on the bus: latches in WAIT, live inputs otherwise.
    mem_op_t     cur_op;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic [3:0]  cur_strobe;
    logic [31:0] cur_data;
    logic [4:0]  cur_dst;
    logic [3:0]  cur_write_enable;

    logic [31:0] load_val;

    // Decode the live instruction into a bus request
    always_comb begin
        live_mem      = bus.m_valid && (is_load(bus.m_op) || is_store(bus.m_op));
        live_size     = op_size(bus.m_op);
        live_misalign = live_mem && misaligned(live_size, bus.m_val[1:0]);
        live_strobe   = store_strobe(bus.m_op, bus.m_val[1:0]);
        live_data     = store_data(bus.m_op, bus.m_store);
        issue         = resetn && (state == IDLE) && live_mem && !live_misalign;
    end

    // Select latched request while waiting so the bus stays stable
    always_comb begin
        if (state == WAIT) begin
            cur_op           = lat_op;
            cur_addr         = lat_addr;
            cur_size         = lat_size;
            cur_strobe       = lat_strobe;
            cur_data         = lat_data;
            cur_dst          = lat_dst;
            cur_write_enable = lat_write_enable;
        end else begin
            cur_op           = bus.m_op;
            cur_addr         = bus.m_val;
            cur_size         = live_size;
            cur_strobe       = live_strobe;
            cur_data         = live_data;
            cur_dst          = bus.m_dst;
            cur_write_enable = bus.m_write_enable;
        end
    end

    mem_stage_load_align u_load_align (
        .op      (cur_op),
        .addr_lo (cur_addr[1:0]),
        .raw     (bus.dresp_data),
        .val     (load_val)
    );

    // Capture the request on issue; cleared by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lat_op           <= NONE;
            lat_addr         <= 32'd0;
            lat_size         <= MSIZE_1;
            lat_strobe       <= 4'd0;
            lat_data         <= 32'd0;
            lat_dst          <= 5'd0;
            lat_write_enable <= 4'd0;
        end else if (issue) begin
            lat_op           <= bus.m_op;
            lat_addr         <= bus.m_val;
            lat_size         <= live_size;
            lat_strobe       <= live_strobe;
            lat_data         <= live_data;
            lat_dst          <= bus.m_dst;
            lat_write_enable <= bus.m_write_enable;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, bus request, stall and writeback outputs
    always_comb begin
        state_nxt          = state;
        bus.dreq_valid     = 1'b0;
        bus.dreq_addr      = cur_addr;
        bus.dreq_size      = cur_size;
        bus.dreq_strobe    = cur_strobe;
        bus.dreq_data      = cur_data;
        bus.m_ready        = 1'b1;
        bus.m_misalign     = 1'b0;
        bus.W_val3         = 32'd0;
        bus.W_dst          = 5'd0;
        bus.W_write_enable = 4'd0;

        if (!resetn) begin
            // Aborted access: drop the request, no writeback.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_valid && (bus.m_op == NONE)) begin
                        bus.W_val3         = bus.m_val;
                        bus.W_dst          = bus.m_dst;
                        bus.W_write_enable = bus.m_write_enable;
                    end else if (live_misalign) begin
                        bus.m_misalign = 1'b1;
                    end else if (issue) begin
                        bus.dreq_valid = 1'b1;
                        if (bus.dresp_data_ok) begin
                            if (is_load(cur_op)) begin
                                bus.W_val3         = load_val;
                                bus.W_dst          = cur_dst;
                                bus.W_write_enable = cur_write_enable;
                            end
                        end else begin
                            bus.m_ready = 1'b0;
                            state_nxt   = WAIT;
                        end
                    end
                end
                WAIT: begin
                    bus.dreq_valid = 1'b1;
                    if (bus.dresp_data_ok) begin
                        state_nxt = IDLE;
                        if (is_load(cur_op)) begin
                            bus.W_val3         = load_val;
                            bus.W_dst          = cur_dst;
                            bus.W_write_enable = cur_write_enable;
                        end
                    end else begin
                        bus.m_ready = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    mem_stage_if bus ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        mem_op_t     op;
        logic [31:0] val;
        logic [31:0] store;
        logic [4:0]  dst;
        logic [3:0]  we;
        logic        ok;
        logic [31:0] rdata;
        logic        e_ready;
        logic        e_mis;
        logic        e_dv;
        logic [1:0]  e_size;
        logic [3:0]  e_strobe;
        logic [31:0] e_ddata;
        logic [31:0] e_wval;
        logic [4:0]  e_wdst;
        logic [3:0]  e_we;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input mem_op_t op, input logic [31:0] val,
                         input logic [31:0] st, input logic [4:0] dst, input logic [3:0] we,
                         input logic ok, input logic [31:0] rd);
        bus.m_valid        = v;
        bus.m_op           = op;
        bus.m_val          = val;
        bus.m_store        = st;
        bus.m_dst          = dst;
        bus.m_write_enable = we;
        bus.dresp_data_ok  = ok;
        bus.dresp_data     = rd;
    endtask

    // Issue a load with one extra stall cycle, scramble the inputs while waiting,
    // then complete and check the extended result against the latched request.
    task automatic wait_load(input mem_op_t op, input logic [31:0] exp_val, input string tag);
        @(negedge clk);
        drive(1'b1, op, 32'h0000_1003, 32'd0, 5'd7, 4'h1, 1'b0, 32'h0);
        #1;
        chk({tag, " issue ready"}, bus.m_ready, 1'b0);
        chk({tag, " issue dv"}, bus.dreq_valid, 1'b1);
        chk({tag, " issue we"}, bus.W_write_enable, 4'h0);
        @(negedge clk);
        drive(1'b1, SW, 32'h5555_5554, 32'hFFFF_FFFF, 5'd9, 4'h0, 1'b0, 32'h0);
        #1;
        chk({tag, " wait ready"}, bus.m_ready, 1'b0);
        chk({tag, " wait dv"}, bus.dreq_valid, 1'b1);
        chk({tag, " wait addr"}, bus.dreq_addr, 32'h0000_1003);
        chk({tag, " wait size"}, bus.dreq_size, MSIZE_1);
        chk({tag, " wait strobe"}, bus.dreq_strobe, 4'h0);
        chk({tag, " wait we"}, bus.W_write_enable, 4'h0);
        @(negedge clk);
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 32'h8011_2233;
        #1;
        chk({tag, " done ready"}, bus.m_ready, 1'b1);
        chk({tag, " done val"}, bus.W_val3, exp_val);
        chk({tag, " done dst"}, bus.W_dst, 5'd7);
        chk({tag, " done we"}, bus.W_write_enable, 4'h1);
        @(negedge clk);
        drive(1'b0, NONE, 32'd0, 32'd0, 5'd0, 4'h0, 1'b1, 32'h0);
        #1;
        chk({tag, " after dv"}, bus.dreq_valid, 1'b0);
        chk({tag, " after ready"}, bus.m_ready, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //         v    op    val           store         dst  we    ok   rdata         rdy  mis  dv   size strobe   ddata         wval          wdst we
        vec[0]  = '{1'b1, LW,  32'h0000_1000, 32'h0,        5'd5, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 32'h0,        32'hDEAD_BEEF, 5'd5, 4'hF};
        vec[1]  = '{1'b1, LB,  32'h0000_1003, 32'h0,        5'd6, 4'hF, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0,        32'hFFFF_FF80, 5'd6, 4'hF};
        vec[2]  = '{1'b1, LBU, 32'h0000_1003, 32'h0,        5'd6, 4'hF, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0,        32'h0000_0080, 5'd6, 4'hF};
        vec[3]  = '{1'b1, LH,  32'h0000_1002, 32'h0,        5'd8, 4'h3, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0,        32'hFFFF_8011, 5'd8, 4'h3};
        vec[4]  = '{1'b1, LHU, 32'h0000_1002, 32'h0,        5'd8, 4'h3, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0,        32'h0000_8011, 5'd8, 4'h3};
        vec[5]  = '{1'b1, LB,  32'h0000_1001, 32'h0,        5'd2, 4'h1, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0,        32'h0000_0022, 5'd2, 4'h1};
        vec[6]  = '{1'b1, LH,  32'h0000_1000, 32'h0,        5'd4, 4'h3, 1'b1, 32'h8011_2233, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0,        32'h0000_2233, 5'd4, 4'h3};
        vec[7]  = '{1'b1, SB,  32'h0000_2001, 32'h0000_00A5, 5'd1, 4'hF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         5'd0, 4'h0};
        vec[8]  = '{1'b1, SH,  32'h0000_2002, 32'h0000_ABCD, 5'd1, 4'hF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 2'd1, 4'b1100, 32'hABCD_ABCD, 32'h0,         5'd0, 4'h0};
        vec[9]  = '{1'b1, SW,  32'h0000_2000, 32'h1122_3344, 5'd1, 4'hF, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 2'd2, 4'b1111, 32'h1122_3344, 32'h0,         5'd0, 4'h0};
        vec[10] = '{1'b1, LW,  32'h0000_1001, 32'h0,        5'd5, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,         5'd0, 4'h0};
        vec[11] = '{1'b1, LH,  32'h0000_1003, 32'h0,        5'd5, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,         5'd0, 4'h0};
        vec[12] = '{1'b1, SW,  32'h0000_2002, 32'h0,        5'd5, 4'hF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,         5'd0, 4'h0};
        vec[13] = '{1'b1, NONE,32'h1234_5678, 32'h0,        5'd3, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h1234_5678, 5'd3, 4'hF};
        vec[14] = '{1'b0, LW,  32'h0000_1000, 32'h0,        5'd5, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,         5'd0, 4'h0};
        vec[15] = '{1'b0, NONE,32'h0,        32'h0,        5'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0,         5'd0, 4'h0};

        // Reset with a live aligned load presented: everything forced quiet.
        resetn = 1'b0;
        drive(1'b1, LW, 32'h0000_1000, 32'h0, 5'd5, 4'hF, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst dv", bus.dreq_valid, 1'b0);
        chk("rst ready", bus.m_ready, 1'b1);
        chk("rst we", bus.W_write_enable, 4'h0);
        chk("rst mis", bus.m_misalign, 1'b0);
        chk("rst wval", bus.W_val3, 32'h0);
        chk("rst wdst", bus.W_dst, 5'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, NONE, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("idle dv", bus.dreq_valid, 1'b0);
        chk("idle ready", bus.m_ready, 1'b1);

        // Single-cycle cases, all of which leave the FSM in IDLE.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i].valid, vec[i].op, vec[i].val, vec[i].store, vec[i].dst,
                  vec[i].we, vec[i].ok, vec[i].rdata);
            #1;
            chk($sformatf("v%0d ready", i), bus.m_ready, vec[i].e_ready);
            chk($sformatf("v%0d mis", i), bus.m_misalign, vec[i].e_mis);
            chk($sformatf("v%0d dv", i), bus.dreq_valid, vec[i].e_dv);
            chk($sformatf("v%0d we", i), bus.W_write_enable, vec[i].e_we);
            if (vec[i].e_dv) begin
                chk($sformatf("v%0d addr", i), bus.dreq_addr, vec[i].val);
                chk($sformatf("v%0d size", i), bus.dreq_size, vec[i].e_size);
                chk($sformatf("v%0d strobe", i), bus.dreq_strobe, vec[i].e_strobe);
            end
            if (vec[i].e_strobe != 4'h0)
                chk($sformatf("v%0d ddata", i), bus.dreq_data, vec[i].e_ddata);
            if (vec[i].e_we != 4'h0) begin
                chk($sformatf("v%0d wval", i), bus.W_val3, vec[i].e_wval);
                chk($sformatf("v%0d wdst", i), bus.W_dst, vec[i].e_wdst);
            end
        end

        // Stalled loads with inputs changing under the wait.
        wait_load(LB, 32'hFFFF_FF80, "lb_wait");
        wait_load(LBU, 32'h0000_0080, "lbu_wait");

        // Stalled store: bus fields held, no writeback on completion.
        @(negedge clk);
        drive(1'b1, SH, 32'h0000_2002, 32'h0000_ABCD, 5'd1, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("sh_wait ready", bus.m_ready, 1'b0);
        chk("sh_wait size", bus.dreq_size, MSIZE_2);
        chk("sh_wait strobe", bus.dreq_strobe, 4'b1100);
        chk("sh_wait data", bus.dreq_data, 32'hABCD_ABCD);
        bus.dresp_data_ok = 1'b1;
        #1;
        chk("sh_done ready", bus.m_ready, 1'b1);
        chk("sh_done we", bus.W_write_enable, 4'h0);

        // Reset while waiting aborts the load; a later store issues normally.
        @(negedge clk);
        drive(1'b1, LW, 32'h0000_1000, 32'h0, 5'd5, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("abort stalled", bus.m_ready, 1'b0);
        resetn = 1'b0;
        #1;
        chk("abort rst dv", bus.dreq_valid, 1'b0);
        chk("abort rst we", bus.W_write_enable, 4'h0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, NONE, 32'h0, 32'h0, 5'd0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("abort post dv", bus.dreq_valid, 1'b0);
        chk("abort post we", bus.W_write_enable, 4'h0);
        chk("abort post ready", bus.m_ready, 1'b1);
        @(negedge clk);
        drive(1'b1, SW, 32'h0000_3000, 32'hCAFE_F00D, 5'd0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("sw dv", bus.dreq_valid, 1'b1);
        chk("sw strobe", bus.dreq_strobe, 4'hF);
        chk("sw data", bus.dreq_data, 32'hCAFE_F00D);
        chk("sw ready", bus.m_ready, 1'b0);
        @(negedge clk);
        bus.dresp_data_ok = 1'b1;
        #1;
        chk("sw done ready", bus.m_ready, 1'b1);
        chk("sw done we", bus.W_write_enable, 4'h0);
        @(negedge clk);
        drive(1'b0, NONE, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("sw after dv", bus.dreq_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
